// File: rtl/hilo_mul_ctrl.sv
// HI/LO register pair and sequencer for MULT/MULTU around an external unsigned
// 32x32 multiplier; also services MTHI/MTLO writes.
module hilo_mul_ctrl #(
   parameter int MUL_WAIT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [63:0] mul_z,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done
);

   localparam int unsigned WAIT = (MUL_WAIT < 1) ? 1 : MUL_WAIT;

   typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;

   state_t      state, state_nx;
   logic [31:0] cnt;
   logic        neg;
   logic [63:0] prod;
   logic [63:0] res;
   logic        last;
   logic [31:0] mag_a, mag_b;

   always_comb begin
      mag_a = (is_signed & op_a[31]) ? (32'd0 - op_a) : op_a;
      mag_b = (is_signed & op_b[31]) ? (32'd0 - op_b) : op_b;
      last  = (cnt == 32'(WAIT - 1));
      res   = neg ? (~prod + 64'd1) : prod;
      busy  = (state != IDLE);
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = MUL;
         MUL:     if (last)  state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         hi    <= '0;
         lo    <= '0;
         mul_a <= '0;
         mul_b <= '0;
         cnt   <= '0;
         neg   <= 1'b0;
         prod  <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               // moves land first; an accepted start overwrites them at commit
               if (hi_we) hi <= wdata;
               if (lo_we) lo <= wdata;
               if (start) begin
                  mul_a <= mag_a;
                  mul_b <= mag_b;
                  neg   <= is_signed & (op_a[31] ^ op_b[31]);
                  cnt   <= '0;
               end
            end
            MUL: begin
               cnt <= cnt + 32'd1;
               if (last) prod <= mul_z;
            end
            FIX: begin
               hi   <= res[63:32];
               lo   <= res[31:0];
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Directed bench for hilo_mul_ctrl with a behavioural unsigned multiplier.
module tb_hilo_mul_ctrl;

   logic        clk = 1'b0;
   logic        reset, start, is_signed, hi_we, lo_we;
   logic [31:0] op_a, op_b, wdata, mul_a, mul_b, hi, lo;
   logic [63:0] mul_z;
   logic        busy, done;

   int errors = 0;
   int checks = 0;
   int n;
   int dones;

   always #5 clk = ~clk;

   assign mul_z = {32'd0, mul_a} * {32'd0, mul_b};

   hilo_mul_ctrl #(.MUL_WAIT(2)) dut (
      .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
      .op_a(op_a), .op_b(op_b), .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one multiply and wait (bounded) for done; n = edges from start to done.
   task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; is_signed = s; op_a = a; op_b = b;
      tick();
      start = 1'b0;
      n = 1;
      while (!done && n < 20) begin
         tick();
         n++;
      end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; is_signed = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op_a = '0; op_b = '0; wdata = '0;
      tick(); tick();
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);
      check("rst_mul", {mul_a, mul_b}, 64'd0);
      reset = 1'b1;
      tick();

      // 1: MULTU max*max with latency and busy width
      start = 1'b1; is_signed = 1'b0; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
      tick();
      start = 1'b0;
      n = 0;
      dones = 0;
      for (int i = 0; i < 3; i++) begin
         if (busy) n++;
         if (done) dones++;
         tick();
      end
      check("t1_busy_cycles", 64'(n), 64'd3);
      check("t1_done_early", 64'(dones), 64'd0);
      check("t1_done", {63'd0, done}, 64'd1);
      check("t1_busy_after", {63'd0, busy}, 64'd0);
      check("t1_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
      tick();
      check("t1_done_drop", {63'd0, done}, 64'd0);

      // 2: signed vs unsigned -3*5
      start = 1'b1; is_signed = 1'b1; op_a = 32'hFFFFFFFD; op_b = 32'h5;
      tick();
      start = 1'b0;
      check("t2_mag", {mul_a, mul_b}, {32'd3, 32'd5});
      n = 1;
      while (!done && n < 20) begin tick(); n++; end
      check("t2_lat", 64'(n), 64'd4);
      check("t2_mult", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
      run(1'b0, 32'hFFFFFFFD, 32'h5);
      check("t2_multu", {hi, lo}, 64'h00000004_FFFFFFF1);

      // 3: most-negative operand
      run(1'b1, 32'h80000000, 32'h80000000);
      check("t3_minmin", {hi, lo}, 64'h40000000_00000000);
      run(1'b1, 32'h80000000, 32'h00000001);
      check("t3_minone", {hi, lo}, 64'hFFFFFFFF_80000000);

      // 4: start while busy is ignored
      tick();
      start = 1'b1; is_signed = 1'b0; op_a = 32'd7; op_b = 32'd6;
      tick();
      op_a = 32'd2; op_b = 32'd2;
      dones = 0;
      tick(); if (done) dones++;
      tick(); if (done) dones++;
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done) dones++;
      end
      check("t4_single_done", 64'(dones), 64'd1);
      check("t4_hilo", {hi, lo}, 64'h00000000_0000002A);

      // 5: MTHI in idle, MTLO while busy
      hi_we = 1'b1; wdata = 32'h12345678;
      tick();
      hi_we = 1'b0;
      check("t5_mthi", {32'd0, hi}, {32'd0, 32'h12345678});
      check("t5_lo_kept", {32'd0, lo}, 64'h2A);
      start = 1'b1; is_signed = 1'b0; op_a = 32'd3; op_b = 32'd5;
      tick();
      start = 1'b0;
      lo_we = 1'b1; wdata = 32'hDEADBEEF;
      n = 1;
      while (!done && n < 20) begin tick(); n++; end
      lo_we = 1'b0;
      check("t5_lo_busy", {hi, lo}, 64'h00000000_0000000F);

      // 6: reset mid-multiply
      run(1'b0, 32'd9, 32'd9);
      check("t6_pre", {hi, lo}, 64'd81);
      start = 1'b1; is_signed = 1'b0; op_a = 32'd11; op_b = 32'd13;
      tick();
      start = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("t6_busy", {63'd0, busy}, 64'd0);
      check("t6_hilo", {hi, lo}, 64'd0);
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         if (done) dones++;
         tick();
      end
      check("t6_no_done", 64'(dones), 64'd0);
      run(1'b0, 32'd3, 32'd3);
      check("t6_lat", 64'(n), 64'd4);
      check("t6_after", {hi, lo}, 64'd9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
